fetch_slot_buffer: RTL and testbench
====================================

# fetch_slot_buffer

Fetch-side slot buffer for the three-wide queue stage. It accepts instruction bundles from fetch into a two-entry bundle FIFO and presents one bundle at a time as `slotvd`, `slot_ins` and `slot_pc` to the queue-count logic. It retires slots according to the returned `queuedCnt`/`queuedOnp`, holds slots that were not queued, and advances to the next bundle once every slot has drained. It flushes on branch miss or fetch redirect.

## Interface
- `QSLOTS`, 3, slots per bundle (fixed at 3; `queuedCnt` is 3 bits).
- `INSN_W`, 52, instruction width.
- `PC_W`, 52, address width.
- `FDEPTH`, 2, bundle FIFO depth (power of two).

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `branchmiss` in 1: flush all state.
- `redirect` in 1: fetch redirect; flush all state.
- `fetch_v` in 1: fetch bundle valid.
- `fetch_mask` in `QSLOTS`: valid slots of the fetch bundle; legal values are 001, 011, 111, 010, 110, 100.
- `fetch_ins` in `QSLOTS*INSN_W`: bundle instructions, slot 0 in the LSBs.
- `fetch_pc` in `QSLOTS*PC_W`: per-slot PCs.
- `fetch_slot_jmp` in `QSLOTS`: per-slot jump flag.
- `fetch_take_branch` in `QSLOTS`: per-slot predicted-taken flag.
- `fetch_rdy` out 1: FIFO not full.
- `slotvd` out `QSLOTS`: valid mask of the presented slots.
- `slot_ins` out `QSLOTS*INSN_W`: presented instructions.
- `slot_pc` out `QSLOTS*PC_W`: presented PCs.
- `slot_jmp` out `QSLOTS`: presented jump flags.
- `take_branch` out `QSLOTS`: presented taken flags.
- `queuedCnt` in 3: count returned by the queue stage.
- `queuedOnp` in `QSLOTS`: per-slot queued flags returned by the queue stage.
- `stall_cnt` out 16: saturating count of cycles with `slotvd != 0` and `queuedCnt == 0`.

## Operation
**Fetch handshake**
- A bundle is pushed when `fetch_v & fetch_rdy` and there is no flush.
- A push with `fetch_mask == 0` is dropped.

**Presentation register**
- The presentation register holds the current bundle. Its state is `slotvd` (valid mask) plus payload.

**Retiring slots**
- Each cycle, `nxt_v = slotvd & ~queuedOnp`.
- If a queued slot i has `slot_jmp[i] | take_branch[i]`, every slot above i is also cleared in `nxt_v`.
- `queuedOnp` bits outside `slotvd` are ignored.
- `queuedCnt` is used only for `stall_cnt` and for the assertion `popcount(queuedOnp & slotvd) == queuedCnt`.

**Loading the next bundle**
- When `nxt_v == 0`, the presentation register loads the FIFO head (pop) if the FIFO is non-empty. Otherwise `slotvd` becomes 0.
- When `nxt_v != 0`, the payload is held and `slotvd <= nxt_v`.

**FIFO**
- Circular buffer with read/write pointers one bit wider than the index; the extra bit gives the wrap and full/empty distinction.
- Full: pointers differ only in the MSB. Empty: pointers are equal.
- `fetch_rdy = !full`, combinational from the registered pointers.
- A simultaneous push and pop while full is not allowed, because `fetch_rdy` is low.
- A simultaneous push and pop while empty is legal only through the bypass (see Configuration).

**Flush**
- `branchmiss | redirect` resets both pointers and clears `slotvd` at the next edge.
- A fetch bundle presented in the flush cycle is discarded.
- Flush has priority over push, pop and retire.

**Reset**
- Pointers 0; `slotvd`, `slot_jmp`, `take_branch` 0; `slot_ins`/`slot_pc` 0; `stall_cnt` 0; `fetch_rdy` 1 the cycle after reset.
- Reset asserted mid-operation behaves identically to reset from power-up.

## Timing
- All outputs are registered except `fetch_rdy`, which is combinational from registered pointers only.
- Push to presentation latency: 2 cycles through the FIFO (1 cycle with bypass).
- Retire feedback is same-cycle: the combinational `queuedOnp` is consumed at the edge that ends the cycle.
- Back-to-back bundles sustain one bundle per cycle when each is fully queued.

## Configuration
- `FSB_BYPASS_EN` defined:
  - When the FIFO is empty and `nxt_v == 0`, the incoming fetch bundle loads directly into the presentation register without being written into the FIFO.
  - Push-to-present latency is 1 cycle.
- `FSB_BYPASS_EN` undefined:
  - Every bundle passes through the FIFO.
  - Push-to-present latency is 2 cycles.

## Structure
- Shared package `fsb_pkg` contains:
  - the `fsb_bundle_t` struct (mask, ins, pc, jmp, tkb);
  - the `QSLOTS` constant;
  - the `fsb_kill_above(mask, idx)` function.
- Sub-module `fsb_fifo`: a parameterised bundle FIFO with push, pop, full, empty and flush, instantiated once.

## Test plan
- Reset, then push 111 bundle A; `queuedOnp = 111` -> `slotvd` goes 000 -> 111 (cycle 2) -> 000, `fetch_rdy = 1` throughout.
- A = 111 presented, `queuedOnp = 001`, then 010, then 100 -> `slotvd` 110, 100, then the next bundle B loads on the third retire edge.
- A = 111 with `take_branch[0] = 1`, `queuedOnp = 001` -> `slotvd` becomes 000 and B loads immediately.
- Hold `queuedOnp = 0` while pushing 3 bundles -> `fetch_rdy` drops after 2 queued bundles, the third push waits, `stall_cnt` increments each cycle.
- FIFO holding 2 bundles with `slotvd = 011`; assert `branchmiss` together with `fetch_v` -> next cycle `slotvd = 0`, FIFO empty, fetch bundle dropped.
- With `FSB_BYPASS_EN` defined, push into an empty buffer -> `slotvd` is valid 1 cycle later. Without it -> valid 2 cycles later.

Source files
------------

// File: rtl/fetch_slot_buffer_pkg.sv
// Shared types and helpers for the fetch slot buffer: bundle struct, geometry constants
// and the slot-kill helper used when a queued slot redirects control flow.
package fsb_pkg;

   localparam int QSLOTS = 3;
   localparam int INSN_W = 52;
   localparam int PC_W   = 52;
   localparam int FDEPTH = 2;

   typedef struct packed {
      logic [QSLOTS-1:0]        mask;
      logic [QSLOTS*INSN_W-1:0] ins;
      logic [QSLOTS*PC_W-1:0]   pc;
      logic [QSLOTS-1:0]        jmp;
      logic [QSLOTS-1:0]        tkb;
   } fsb_bundle_t;

   // Keeps slots 0..idx of mask and clears every slot above idx.
   function automatic logic [QSLOTS-1:0] fsb_kill_above(input logic [QSLOTS-1:0] mask,
                                                        input int idx);
      logic [QSLOTS-1:0] keep;
      keep = '0;
      for (int b = 0; b < QSLOTS; b++) begin
         keep[b] = (b <= idx);
      end
      return mask & keep;
   endfunction

endpackage

// File: rtl/fetch_slot_buffer_if.sv
// Bus between fetch / queue stage (master) and the fetch slot buffer (slave).
interface fetch_slot_buffer_if;
   import fsb_pkg::*;

   logic                     branchmiss;
   logic                     redirect;
   logic                     fetch_v;
   logic [QSLOTS-1:0]        fetch_mask;
   logic [QSLOTS*INSN_W-1:0] fetch_ins;
   logic [QSLOTS*PC_W-1:0]   fetch_pc;
   logic [QSLOTS-1:0]        fetch_slot_jmp;
   logic [QSLOTS-1:0]        fetch_take_branch;
   logic                     fetch_rdy;
   logic [QSLOTS-1:0]        slotvd;
   logic [QSLOTS*INSN_W-1:0] slot_ins;
   logic [QSLOTS*PC_W-1:0]   slot_pc;
   logic [QSLOTS-1:0]        slot_jmp;
   logic [QSLOTS-1:0]        take_branch;
   logic [2:0]               queuedCnt;
   logic [QSLOTS-1:0]        queuedOnp;
   logic [15:0]              stall_cnt;

   modport master (
      output branchmiss, redirect, fetch_v, fetch_mask, fetch_ins, fetch_pc,
             fetch_slot_jmp, fetch_take_branch, queuedCnt, queuedOnp,
      input  fetch_rdy, slotvd, slot_ins, slot_pc, slot_jmp, take_branch, stall_cnt
   );

   modport slave (
      input  branchmiss, redirect, fetch_v, fetch_mask, fetch_ins, fetch_pc,
             fetch_slot_jmp, fetch_take_branch, queuedCnt, queuedOnp,
      output fetch_rdy, slotvd, slot_ins, slot_pc, slot_jmp, take_branch, stall_cnt
   );

endinterface

// File: rtl/fetch_slot_buffer_fifo.sv
// Circular bundle FIFO; pointers carry one extra wrap bit to tell full from empty.
module fsb_fifo
   import fsb_pkg::*;
#(
   parameter int DEPTH = FDEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_flush,
   input  logic        i_push,
   input  logic        i_pop,
   input  fsb_bundle_t i_wdata,
   output fsb_bundle_t o_rdata,
   output logic        o_full,
   output logic        o_empty
);

   localparam int AW = $clog2(DEPTH);

   fsb_bundle_t r_mem [DEPTH];
   logic [AW:0] r_wrPtr;
   logic [AW:0] r_rdPtr;

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (i_push) r_wrPtr <= r_wrPtr + (AW+1)'(1);
         if (i_pop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !i_flush && i_push) r_mem[r_wrPtr[AW-1:0]] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rdPtr[AW-1:0]];
   assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign o_empty = (r_wrPtr == r_rdPtr);

endmodule

// File: rtl/fetch_slot_buffer.sv
// Fetch slot buffer: two-bundle FIFO feeding a presentation register that retires queued slots.
// Define FSB_BYPASS_EN to let a bundle skip the empty FIFO and present one cycle after push.
module fetch_slot_buffer
   import fsb_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   fetch_slot_buffer_if.slave  bus
);

   logic                     w_flush;
   logic                     w_full;
   logic                     w_empty;
   logic                     w_pushReq;
   logic                     w_bypass;
   logic                     w_fifoPush;
   logic                     w_fifoPop;
   logic                     w_advance;
   logic                     w_stall;
   logic [QSLOTS-1:0]        w_queued;
   logic [QSLOTS-1:0]        w_nxtV;
   fsb_bundle_t              w_head;
   fsb_bundle_t              w_fetchBundle;

   logic [QSLOTS-1:0]        r_slotvd;
   logic [QSLOTS*INSN_W-1:0] r_ins;
   logic [QSLOTS*PC_W-1:0]   r_pc;
   logic [QSLOTS-1:0]        r_jmp;
   logic [QSLOTS-1:0]        r_tkb;
   logic [15:0]              r_stallCnt;

   assign w_flush = bus.branchmiss | bus.redirect;

   assign w_fetchBundle.mask = bus.fetch_mask;
   assign w_fetchBundle.ins  = bus.fetch_ins;
   assign w_fetchBundle.pc   = bus.fetch_pc;
   assign w_fetchBundle.jmp  = bus.fetch_slot_jmp;
   assign w_fetchBundle.tkb  = bus.fetch_take_branch;

   // A queued slot that jumps or is predicted taken makes everything younger than it dead.
   always_comb begin
      w_queued = r_slotvd & bus.queuedOnp;
      w_nxtV   = r_slotvd & ~bus.queuedOnp;
      for (int i = 0; i < QSLOTS; i++) begin
         if (w_queued[i] && (r_jmp[i] || r_tkb[i])) w_nxtV = fsb_kill_above(w_nxtV, i);
      end
   end

   assign w_advance = (w_nxtV == '0);
   assign w_pushReq = bus.fetch_v & bus.fetch_rdy & ~w_flush & (bus.fetch_mask != '0);

`ifdef FSB_BYPASS_EN
   assign w_bypass = w_advance & w_empty & w_pushReq;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_fifoPush = w_pushReq & ~w_bypass;
   assign w_fifoPop  = w_advance & ~w_empty & ~w_flush;

   fsb_fifo #(.DEPTH(FDEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_flush),
      .i_push  (w_fifoPush),
      .i_pop   (w_fifoPop),
      .i_wdata (w_fetchBundle),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Payload is only rewritten when a new bundle arrives; partial retires just shrink the mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_slotvd <= '0;
         r_ins    <= '0;
         r_pc     <= '0;
         r_jmp    <= '0;
         r_tkb    <= '0;
      end else if (w_flush) begin
         r_slotvd <= '0;
      end else if (!w_advance) begin
         r_slotvd <= w_nxtV;
      end else if (w_bypass) begin
         r_slotvd <= w_fetchBundle.mask;
         r_ins    <= w_fetchBundle.ins;
         r_pc     <= w_fetchBundle.pc;
         r_jmp    <= w_fetchBundle.jmp;
         r_tkb    <= w_fetchBundle.tkb;
      end else if (!w_empty) begin
         r_slotvd <= w_head.mask;
         r_ins    <= w_head.ins;
         r_pc     <= w_head.pc;
         r_jmp    <= w_head.jmp;
         r_tkb    <= w_head.tkb;
      end else begin
         r_slotvd <= '0;
      end
   end

   assign w_stall = (r_slotvd != '0) && (bus.queuedCnt == 3'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stallCnt <= '0;
      end else if (w_stall && (r_stallCnt != 16'hFFFF)) begin
         r_stallCnt <= r_stallCnt + 16'd1;
      end
   end

   assign bus.fetch_rdy   = ~w_full;
   assign bus.slotvd      = r_slotvd;
   assign bus.slot_ins    = r_ins;
   assign bus.slot_pc     = r_pc;
   assign bus.slot_jmp    = r_jmp;
   assign bus.take_branch = r_tkb;
   assign bus.stall_cnt   = r_stallCnt;

`ifndef SYNTHESIS
   // The queue stage's count must agree with the slots it actually took.
   a_cntMatches: assert property (@(posedge clk) disable iff (rst)
      $countones(bus.queuedOnp & r_slotvd) == int'(bus.queuedCnt));

   a_noPushWhenFull: assert property (@(posedge clk) disable iff (rst)
      !(w_fifoPush && w_full));
`endif

endmodule

// File: tb/tb_fetch_slot_buffer.sv
// Randomized scoreboard bench for fetch_slot_buffer against a queue-based behavioural model.
module tb_fetch_slot_buffer;
   import fsb_pkg::*;

   localparam int IW = QSLOTS * INSN_W;

   typedef struct {
      int                tgt;
      logic [QSLOTS-1:0] v;
      logic [IW-1:0]     ins;
      logic [IW-1:0]     pc;
      logic [QSLOTS-1:0] jmp;
      logic [QSLOTS-1:0] tkb;
      logic              rdy;
      logic [15:0]       stall;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cycleCnt = 0;
   int   compared = 0;
   int   mismatched = 0;

   exp_t        expQ[$];
   fsb_bundle_t mFifo[$];
   fsb_bundle_t mCur;
   logic [15:0] mStall;
   logic [2:0]  legalMask[6];

   fetch_slot_buffer_if bus();

   fetch_slot_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkField(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s @cycle %0d: got %0h expected %0h", nm, cycleCnt, act, exp);
      end
   endtask

   // Spec-level model: a bounded queue of bundles plus the currently presented bundle.
   task automatic modelStep(input logic r, input logic fl, input logic fv,
                            input fsb_bundle_t fb, input logic [2:0] onp);
      logic [2:0] nxt;
      bit         acc;
      if (r) begin
         mFifo.delete();
         mCur   = '0;
         mStall = '0;
         return;
      end
      if (mCur.mask != 0 && $countones(onp & mCur.mask) == 0 && mStall != 16'hFFFF)
         mStall = mStall + 16'd1;
      if (fl) begin
         mFifo.delete();
         mCur.mask = '0;
         return;
      end
      nxt = mCur.mask & ~onp;
      for (int i = 0; i < QSLOTS; i++) begin
         if (mCur.mask[i] && onp[i] && (mCur.jmp[i] || mCur.tkb[i])) begin
            for (int j = i + 1; j < QSLOTS; j++) nxt[j] = 1'b0;
            break;
         end
      end
      acc = fv && (mFifo.size() < FDEPTH) && (fb.mask != 0);
      if (nxt == 0) begin
         if (mFifo.size() > 0) begin
            mCur = mFifo.pop_front();
         end
`ifdef FSB_BYPASS_EN
         else if (acc) begin
            mCur = fb;
            acc  = 0;
         end
`endif
         else begin
            mCur.mask = '0;
         end
      end else begin
         mCur.mask = nxt;
      end
      if (acc) mFifo.push_back(fb);
   endtask

   task automatic applyStimulus(input logic r, input logic bm, input logic rd, input logic fv,
                                input logic [2:0] fm, input logic [2:0] onp,
                                input logic [2:0] jm, input logic [2:0] tk);
      fsb_bundle_t   fb;
      logic [159:0]  rnd;
      exp_t          e;
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) rnd[k*32 +: 32] = $urandom;
      fb.ins = rnd[IW-1:0];
      for (int k = 0; k < 5; k++) rnd[k*32 +: 32] = $urandom;
      fb.pc   = rnd[IW-1:0];
      fb.mask = fm;
      fb.jmp  = jm;
      fb.tkb  = tk;
      rst                   = r;
      bus.branchmiss        = bm;
      bus.redirect          = rd;
      bus.fetch_v           = fv;
      bus.fetch_mask        = fb.mask;
      bus.fetch_ins         = fb.ins;
      bus.fetch_pc          = fb.pc;
      bus.fetch_slot_jmp    = fb.jmp;
      bus.fetch_take_branch = fb.tkb;
      bus.queuedOnp         = onp;
      bus.queuedCnt         = 3'($countones(onp & bus.slotvd));
      modelStep(r, bm | rd, fv, fb, onp);
      e.tgt   = cycleCnt + 1;
      e.v     = mCur.mask;
      e.ins   = mCur.ins;
      e.pc    = mCur.pc;
      e.jmp   = mCur.jmp;
      e.tkb   = mCur.tkb;
      e.rdy   = (mFifo.size() < FDEPTH);
      e.stall = mStall;
      expQ.push_back(e);
   endtask

   // Monitor: after every edge, compare the DUT against whatever was predicted for that edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         while (expQ.size() > 0 && expQ[0].tgt <= cycleCnt) begin
            e = expQ.pop_front();
            checkField("slotvd", IW'(bus.slotvd), IW'(e.v));
            checkField("fetch_rdy", IW'(bus.fetch_rdy), IW'(e.rdy));
            checkField("stall_cnt", IW'(bus.stall_cnt), IW'(e.stall));
            checkField("slot_ins", bus.slot_ins, e.ins);
            checkField("slot_pc", bus.slot_pc, e.pc);
            checkField("slot_jmp", IW'(bus.slot_jmp), IW'(e.jmp));
            checkField("take_branch", IW'(bus.take_branch), IW'(e.tkb));
         end
      end
   end

   initial begin
      logic [2:0] jm;
      logic [2:0] tk;
      logic [2:0] onp;
      legalMask = '{3'b001, 3'b011, 3'b111, 3'b010, 3'b110, 3'b100};
      mCur   = '0;
      mStall = '0;
      bus.branchmiss        = 1'b0;
      bus.redirect          = 1'b0;
      bus.fetch_v           = 1'b0;
      bus.fetch_mask        = '0;
      bus.fetch_ins         = '0;
      bus.fetch_pc          = '0;
      bus.fetch_slot_jmp    = '0;
      bus.fetch_take_branch = '0;
      bus.queuedOnp         = '0;
      bus.queuedCnt         = '0;

      repeat (3) applyStimulus(1, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
      // Single full bundle then retire it whole.
      applyStimulus(0, 0, 0, 1, 3'b111, 3'b000, 3'b000, 3'b000);
      repeat (2) applyStimulus(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
      applyStimulus(0, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000);
      // Taken branch in slot 0 kills the rest of the bundle.
      applyStimulus(0, 0, 0, 1, 3'b111, 3'b000, 3'b000, 3'b001);
      applyStimulus(0, 0, 0, 1, 3'b011, 3'b000, 3'b000, 3'b000);
      applyStimulus(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
      applyStimulus(0, 0, 0, 0, 3'b000, 3'b001, 3'b000, 3'b000);
      // Fill while stalled, then flush with a bundle on the fetch side.
      repeat (5) applyStimulus(0, 0, 0, 1, 3'b111, 3'b000, 3'b000, 3'b000);
      applyStimulus(0, 1, 0, 1, 3'b011, 3'b000, 3'b000, 3'b000);
      applyStimulus(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
      // Dropped empty-mask push.
      applyStimulus(0, 0, 0, 1, 3'b000, 3'b000, 3'b000, 3'b000);

      for (int n = 0; n < 4000; n++) begin
         for (int b = 0; b < QSLOTS; b++) begin
            jm[b] = ($urandom_range(0, 7) == 0);
            tk[b] = ($urandom_range(0, 7) == 0);
         end
         onp = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom);
         applyStimulus(($urandom_range(0, 999) == 0), ($urandom_range(0, 39) == 0),
                       ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                       legalMask[$urandom_range(0, 5)], onp, jm, tk);
      end
      applyStimulus(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);

      repeat (3) @(posedge clk);
      #3;
      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
